// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the iterative shifter state encoding.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;
endpackage : alu_pkg

// File: rtl/bit32_shift_left_logical_01.sv
// Combinational 1-bit left shift stage: one mux2_1 per bit, zero fill into bit 0.
module bit32_shift_left_logical_01
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic         b,
  output logic [W-1:0] c
);

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_mux
      if (i == 0) begin : g_lsb
        assign c[0] = b ? 1'b0 : a[0];
      end else begin : g_bit
        assign c[i] = b ? a[i-1] : a[i];
      end
    end
  endgenerate

endmodule : bit32_shift_left_logical_01

// File: rtl/bit32_shift_left_logical_seq.sv
// Iterative shift-left-logical unit: one bit per cycle, start/busy/done handshake.
module bit32_shift_left_logical_seq
  import alu_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int SHW_P   = SHW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_P-1:0] a,
  input  logic [SHW_P-1:0]   shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_P-1:0] result
);

  shift_state_e       r_state;
  logic [WIDTH_P-1:0] r_data;
  logic [SHW_P-1:0]   r_cnt;
  logic [WIDTH_P-1:0] r_result;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH_P-1:0] w_shifted;
  logic               w_shift_en;

  assign w_shift_en = (r_state == ST_SHIFT);

  bit32_shift_left_logical_01 #(
    .W (WIDTH_P)
  ) u_stage (
    .a (r_data),
    .b (w_shift_en),
    .c (w_shifted)
  );

  // Operands are only taken in IDLE or DONE, so back-to-back ops need no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_data <= a;
            r_cnt  <= shamt;
            if (shamt == '0) begin
              r_state  <= ST_DONE;
              r_result <= a;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_cnt  <= r_cnt - SHW_P'(1);
          if (r_cnt == SHW_P'(1)) begin
            r_state  <= ST_DONE;
            r_result <= w_shifted;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule : bit32_shift_left_logical_seq

// File: tb/tb_bit32_shift_left_logical_seq.sv
// Scoreboard bench: driver pushes expected result and done cycle, monitor pops on done.
module tb_bit32_shift_left_logical_seq;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_cmp;
  int   n_mis;
  int   nb;
  bit   found;

  bit32_shift_left_logical_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_done: got result %h with no op outstanding", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Issue one op, drop start, then wait (bounded) for done while counting busy cycles.
  task automatic run_op(input logic [31:0] ia, input logic [4:0] ish,
                        input logic [31:0] er, output int nbusy);
    bit seen;
    @(negedge clk);
    start = 1'b1; a = ia; shamt = ish;
    @(posedge clk);
    sb.push_back('{er, cyc + int'(ish) + 1});
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    if (!seen) begin
      n_cmp++;
      n_mis++;
      $display("FAIL timeout: got no done expected done for a=%h shamt=%0d", ia, ish);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_mis = 0;
    rst = 1'b1; start = 1'b0; a = 32'h0; shamt = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;

    run_op(32'h0000_0001, 5'd5, 32'h0000_0020, nb);
    check("busy_cycles_5", nb, 32'd5);
    run_op(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, nb);
    check("busy_cycles_0", nb, 32'd0);
    run_op(32'h8000_0001, 5'd31, 32'h8000_0000, nb);
    check("busy_cycles_31", nb, 32'd31);
    run_op(32'h1234_5678, 5'd8, 32'h3456_7800, nb);
    run_op(32'hC000_0001, 5'd1, 32'h8000_0002, nb);

    // Back-to-back: start held, second op presented during the first op's DONE cycle.
    @(negedge clk);
    start = 1'b1; a = 32'h0000_000F; shamt = 5'd4;
    @(posedge clk);
    sb.push_back('{32'h0000_00F0, cyc + 5});
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++; n_mis++;
      $display("FAIL b2b_timeout: got no done expected done for op1");
    end
    a = 32'h0000_0001; shamt = 5'd1;
    @(posedge clk);
    sb.push_back('{32'h0000_0002, cyc + 2});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_drained", sb.size(), 32'd0);
    sb.delete();

    // Reset mid-shift discards the op; no done may follow.
    @(negedge clk);
    start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'h0);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) found = 1'b1;
    end
    check("no_activity_after_rst", {31'd0, found}, 32'd0);
    run_op(32'h0000_0005, 5'd3, 32'h0000_0028, nb);

    // Start pulsed during SHIFT with other operands must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'h0000_0003; shamt = 5'd2;
    @(posedge clk);
    sb.push_back('{32'h0000_000C, cyc + 3});
    @(negedge clk);
    start = 1'b1; a = 32'hFFFF_0000; shamt = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ignore_drained", sb.size(), 32'd0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_bit32_shift_left_logical_seq
